// File: rtl/seg7_display_arbiter_pkg.sv
// Shared definitions for the 7-segment display arbiter: display codes,
// ownership state encoding and active-low segment patterns {g,f,e,d,c,b,a}.
package seg7_pkg;

  // Display codes beyond the decimal digits
  localparam logic [3:0] CODE_A     = 4'd10;
  localparam logic [3:0] CODE_B     = 4'd11;
  localparam logic [3:0] CODE_DASH  = 4'd12;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Who currently owns the display
  typedef enum logic {
    SHOW_A = 1'b0,
    SHOW_B = 1'b1
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_A     = 7'b000_1000;
  localparam logic [6:0] SEG_B     = 7'b000_0011;
  localparam logic [6:0] SEG_DASH  = 7'b011_1111;
  localparam logic [6:0] SEG_OFF   = 7'b111_1111;

  // All digit enables off (active-low)
  localparam logic [3:0] DIGIT_OFF = 4'b1111;

endpackage

// File: rtl/seg7_display_arbiter_decode.sv
// Combinational 4-bit code to active-low 7-segment pattern decoder.
// Codes 13..15 (including CODE_BLANK) light nothing.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // Map each display code to its segment pattern
  always_comb begin
    o_seg = SEG_OFF;
    case (i_code)
      4'd0:      o_seg = SEG_0;
      4'd1:      o_seg = SEG_1;
      4'd2:      o_seg = SEG_2;
      4'd3:      o_seg = SEG_3;
      4'd4:      o_seg = SEG_4;
      4'd5:      o_seg = SEG_5;
      4'd6:      o_seg = SEG_6;
      4'd7:      o_seg = SEG_7;
      4'd8:      o_seg = SEG_8;
      4'd9:      o_seg = SEG_9;
      CODE_A:    o_seg = SEG_A;
      CODE_B:    o_seg = SEG_B;
      CODE_DASH: o_seg = SEG_DASH;
      default:   o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Display arbiter: scans a 4-digit 7-segment display and shares it between a
// continuous source A (with per-digit blinking) and a pulse-requested source B
// that holds the display for HOLD_TICKS second ticks.
//
// Handshake: b_req is a single-cycle pulse with no ready; every b_req is
// accepted in the cycle it is high. In SHOW_A it starts a message, in SHOW_B
// it restarts the hold with the new b_digits, and it takes priority over a
// second tick in the same cycle. b_busy reports ownership one cycle later.
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 16384,
  parameter int SEC_DIV    = 134217728,
  parameter int HOLD_TICKS = 4
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a_digits,
  input  logic [3:0]  blink_mask,
  input  logic        b_req,
  input  logic [15:0] b_digits,
  output logic        b_busy,
  output logic [3:0]  DIGIT,
  output logic [6:0]  DISPLAY,
  output state_t      o_dbg_state
);

  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SEC_W     = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  // A hold of zero would never show B, so it is promoted to one tick
  localparam int HOLD_LOAD = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
  localparam int HOLD_W    = $clog2(HOLD_LOAD + 1);

  logic [SCAN_W-1:0] r_scan_cnt;
  logic [SEC_W-1:0]  r_sec_cnt;
  logic [1:0]        r_dig_idx;
  logic              r_blink_phase;
  state_t            r_state;
  logic [HOLD_W-1:0] r_hold;
  logic [15:0]       r_b_latch;
  logic              r_b_busy;
  logic [3:0]        r_digit;
  logic [6:0]        r_display;

  logic              w_scan_wrap;
  logic              w_tick;
  logic [15:0]       w_owner;
  logic [3:0]        w_raw_code;
  logic              w_blank;
  logic [3:0]        w_code;
  logic [3:0]        w_digit_sel;
  logic [6:0]        w_seg;

  assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign w_tick      = (r_sec_cnt == SEC_W'(SEC_DIV - 1));

  // Pick the code for the digit being scanned next, applying A's blink
  always_comb begin
    w_owner = (r_state == SHOW_B) ? r_b_latch : a_digits;
    case (r_dig_idx)
      2'd0:    w_raw_code = w_owner[3:0];
      2'd1:    w_raw_code = w_owner[7:4];
      2'd2:    w_raw_code = w_owner[11:8];
      default: w_raw_code = w_owner[15:12];
    endcase
    w_blank     = (r_state == SHOW_A) && blink_mask[r_dig_idx] && r_blink_phase;
    w_code      = w_blank ? CODE_BLANK : w_raw_code;
    w_digit_sel = ~(4'b0001 << r_dig_idx);
  end

  seg7_decode u_decode (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  // Digit scan: on each slot wrap, light the indexed digit and advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= 2'd0;
      r_digit    <= DIGIT_OFF;
      r_display  <= SEG_OFF;
    end else if (w_scan_wrap) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= r_dig_idx + 2'd1;
      r_digit    <= w_digit_sel;
      r_display  <= w_seg;
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  // Second-tick counter (restarted by any b_req) and blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec_cnt     <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      if (b_req || w_tick) begin
        r_sec_cnt <= '0;
      end else begin
        r_sec_cnt <= r_sec_cnt + SEC_W'(1);
      end
      if (w_tick) begin
        r_blink_phase <= ~r_blink_phase;
      end
    end
  end

  // Ownership FSM: B holds the display for a number of ticks, then A returns
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= SHOW_A;
      r_hold    <= '0;
      r_b_latch <= 16'hFFFF;
      r_b_busy  <= 1'b0;
    end else begin
      case (r_state)
        SHOW_A: begin
          if (b_req) begin
            r_b_latch <= b_digits;
            r_hold    <= HOLD_W'(HOLD_LOAD);
            r_state   <= SHOW_B;
            r_b_busy  <= 1'b1;
          end
        end
        SHOW_B: begin
          if (b_req) begin
            r_b_latch <= b_digits;
            r_hold    <= HOLD_W'(HOLD_LOAD);
          end else if (w_tick) begin
            if (r_hold == HOLD_W'(1)) begin
              r_state  <= SHOW_A;
              r_b_busy <= 1'b0;
            end else begin
              r_hold <= r_hold - HOLD_W'(1);
            end
          end
        end
        default: begin
          r_state  <= SHOW_A;
          r_b_busy <= 1'b0;
        end
      endcase
    end
  end

  assign b_busy      = r_b_busy;
  assign DIGIT       = r_digit;
  assign DISPLAY     = r_display;
  assign o_dbg_state = r_state;

endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Owns the 4-digit 7-segment display and shares it between two requesters: the game datapath (source A, continuous) and a transient message source (source B, pulse-requested). Sequences the digit scan, applies per-digit blinking to A, and grants B the display for a fixed number of second ticks before returning to A. Sits between the game FSM/value registers and the board's DIGIT/DISPLAY pins.

## Interface
- SCAN_DIV, 16384: clk cycles per digit slot (simulation: 8).
- SEC_DIV, 134217728: clk cycles per second tick (simulation: 32).
- HOLD_TICKS, 4: second ticks that B keeps the display; 0 is treated as 1.

- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- a_digits  in  16  source A codes; [3:0] = digit 0 (rightmost) … [15:12] = digit 3.
- blink_mask  in  4  bit i = 1: A's digit i blinks.
- b_req  in  1  one-cycle request pulse from source B.
- b_digits  in  16  source B codes, same packing; sampled only on an accepted b_req.
- b_busy  out  1  high while B owns the display.
- DIGIT  out  4  active-low one-hot digit enable.
- DISPLAY  out  7  active-low segments {g,f,e,d,c,b,a}.

## Operation
- Code map: 0–9 decimal digits, 10 'A', 11 'b', 12 '-', 13–15 blank (all segments off).
- States: SHOW_A (reset), SHOW_B.
- SHOW_A: b_req → latch b_digits into b_latch, clear sec counter, load hold = max(HOLD_TICKS,1), go to SHOW_B.
- SHOW_B: on sec tick, hold == 1 → SHOW_A; otherwise hold decrements. b_req in SHOW_B → relatch b_digits, clear sec counter, reload hold (restart); b_req on the same cycle as a tick wins over the tick.
- Scan: scan counter 0..SCAN_DIV-1, free-running; on wrap, digit index advances 0→1→2→3→0 and the selected digit's code is sampled from the owner (a_digits or b_latch) and decoded.
- Blink: blink_phase toggles on every sec tick. In SHOW_A, if blink_mask[i] and blink_phase = 1, digit i shows blank. No blinking in SHOW_B.
- Sec counter free-running 0..SEC_DIV-1; tick is high in the cycle where it equals SEC_DIV-1; cleared only by accepted b_req or rst.
- b_busy = (state == SHOW_B), registered.

## Timing
- Reset values: DIGIT = 4'b1111, DISPLAY = 7'b111_1111, b_busy = 0, state SHOW_A, digit index 0, blink_phase 0, all counters 0, b_latch = 16'hFFFF.
- First lit digit: DIGIT = 4'b1110 on the edge ending cycle SCAN_DIV-1 after reset release.
- DIGIT/DISPLAY are registered and change only on scan wrap edges; an input change is visible within one slot (≤ SCAN_DIV cycles) of the owner's digit being selected.
- b_req accepted at cycle t: b_busy high from t+1 for exactly HOLD_TICKS·SEC_DIV cycles (absent further requests).
- Ownership switches take effect at the next scan wrap; the current slot is not cut short.
- rst mid-message: B is discarded immediately, display blank until the first slot.

## Structure
- Package seg7_pkg: code constants (CODE_A = 10, CODE_B = 11, CODE_DASH = 12, CODE_BLANK = 15), state enum {SHOW_A, SHOW_B}, segment patterns.
- One combinational sub-module seg7_decode (4-bit code → 7-bit active-low segments); registers stay in the arbiter.

## Test plan
- Reset, then SCAN_DIV=8, a_digits=16'h1234: DIGIT cycles 1110→1101→1011→0111 every 8 cycles; DISPLAY = '4','3','2','1' patterns respectively.
- b_req with b_digits=16'hCABC, SEC_DIV=32, HOLD_TICKS=4: b_busy high exactly 128 cycles; display shows '-','A','b','-' (digit 3..0 order C,A,B,C); then returns to A's 1234.
- Second b_req 50 cycles into SHOW_B with b_digits=16'h9999: hold restarts, b_busy stays high 128 more cycles, display shows 9999.
- blink_mask=4'b0001, a_digits=16'h5678: digit 0 alternates '8'/blank every 32 cycles; digits 1–3 steady; no blink while b_busy.
- b_req coincident with the final hold tick: stays in SHOW_B, hold reloaded, new b_digits shown.
- rst asserted during SHOW_B: next cycle b_busy=0, DIGIT=1111, DISPLAY=1111111; after release, A content resumes.
